fp_wb_ctrl: RTL

Writeback controller and scoreboard for the FP register file. Buffers results from the multi-cycle FP execution units in a small FIFO and arbitrates them against FP load data onto the regfile's single write port (fwe/fwa3/fwd3). It also tracks outstanding destination registers so decode can stall on RAW/WAW hazards. It sits between the FP datapath/load path and the FP register file.

---
 rtl/fp_wb_ctrl_if.sv | 38 +++
 rtl/fp_wb_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/fp_wb_ctrl_if.sv
// Bundle of FP writeback controller signals: issue, result, load, decode check and regfile write port.
interface fp_wb_ctrl_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             issue_valid;
  logic [4:0]       issue_fd;
  logic             res_valid;
  logic             res_ready;
  logic [4:0]       res_fd;
  logic [WIDTH-1:0] res_data;
  logic             ld_valid;
  logic [4:0]       ld_fd;
  logic [WIDTH-1:0] ld_data;
  logic [4:0]       chk_fs;
  logic [4:0]       chk_ft;
  logic [4:0]       chk_fd;
  logic             hazard;
  logic [31:0]      pending;
  logic             fwe;
  logic [4:0]       fwa3;
  logic [WIDTH-1:0] fwd3;
  logic [CW-1:0]    count;

  modport master (
    output issue_valid, issue_fd, res_valid, res_fd, res_data,
           ld_valid, ld_fd, ld_data, chk_fs, chk_ft, chk_fd,
    input  res_ready, hazard, pending, fwe, fwa3, fwd3, count
  );

  modport slave (
    input  issue_valid, issue_fd, res_valid, res_fd, res_data,
           ld_valid, ld_fd, ld_data, chk_fs, chk_ft, chk_fd,
    output res_ready, hazard, pending, fwe, fwa3, fwd3, count
  );
endinterface

// File: rtl/fp_wb_ctrl.sv
// FP writeback controller: result FIFO arbitrated against load data onto the regfile
// write port, plus a pending-destination scoreboard for decode hazard detection.
module fp_wb_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        reset_n,
  fp_wb_ctrl_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [4:0]       mem_fd   [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_n;
  logic [31:0]      pending_q;
  logic [31:0]      pending_n;
  logic             fwe_q;
  logic [4:0]       fwa3_q;
  logic [WIDTH-1:0] fwd3_q;

  logic res_ready_c;
  logic accept_c;
  logic push_c;
  logic pop_c;

  // Readiness depends only on registered occupancy; a same-edge pop gives no credit.
  assign res_ready_c = (count_q < CW'(DEPTH));
  assign accept_c    = bus.res_valid && res_ready_c;
  assign push_c      = accept_c && (bus.res_fd != 5'd0);
  assign pop_c       = !bus.ld_valid && (count_q != '0);

  always_comb begin
    count_n = count_q;
    if (push_c && !pop_c)      count_n = count_q + CW'(1);
    else if (pop_c && !push_c) count_n = count_q - CW'(1);
  end

  // Clear on commit first so a same-edge issue to that register wins.
  always_comb begin
    pending_n = pending_q;
    if (fwe_q) pending_n[fwa3_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_fd != 5'd0)) pending_n[bus.issue_fd] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_data[wr_ptr] <= bus.res_data;
      mem_fd[wr_ptr]   <= bus.res_fd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      fwe_q     <= 1'b0;
      fwa3_q    <= '0;
      fwd3_q    <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count_q   <= count_n;
      pending_q <= pending_n;
      if (bus.ld_valid) begin
        fwe_q  <= (bus.ld_fd != 5'd0);
        fwa3_q <= bus.ld_fd;
        fwd3_q <= bus.ld_data;
      end else if (pop_c) begin
        fwe_q  <= 1'b1;
        fwa3_q <= mem_fd[rd_ptr];
        fwd3_q <= mem_data[rd_ptr];
      end else begin
        fwe_q  <= 1'b0;
      end
    end
  end

  assign bus.res_ready = res_ready_c;
  assign bus.count     = count_q;
  assign bus.pending   = pending_q;
  assign bus.fwe       = fwe_q;
  assign bus.fwa3      = fwa3_q;
  assign bus.fwd3      = fwd3_q;
  assign bus.hazard    = pending_q[bus.chk_fs] | pending_q[bus.chk_ft] | pending_q[bus.chk_fd];
endmodule
